siso_frame_deser: RTL

//  Downstream consumer of the serial shift-register stage. Hunts the incoming serial
//  bit stream for a sync word, then assembles the next W data bits (MSB first) plus
//  one even-parity bit into a parallel word. Good words are presented on a

---
 rtl/siso_frame_deser.sv | 124 ++++++++++++
 1 files changed

// File: rtl/siso_frame_deser.sv
`default_nettype none
// ============================================================================
// Module   : siso_frame_deser
// Function : Sync-word hunter and serial-to-parallel word assembler with
//            even-parity check and a single-entry valid/ready output register.
// Revision : 1.0
// ============================================================================
module siso_frame_deser #(
  parameter int              W    = 8,
  parameter int              SW   = 4,
  parameter logic [SW-1:0]   SYNC = 4'b1011
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         bit_en_in,
  input  logic         d_in,
  input  logic         ready_in,
  input  logic         clr_ovf_in,
  output logic [W-1:0] word_out,
  output logic         valid_out,
  output logic         parity_err_out,
  output logic         overflow_out,
  output logic         busy_out
);

  localparam int FW = $clog2(SW + 1);
  localparam int BW = $clog2(W + 1);

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  localparam logic [FW-1:0] c_fill_full = FW'(SW);
  localparam logic [FW-1:0] c_fill_arm  = FW'(SW - 1);
  localparam logic [FW-1:0] c_fill_one  = FW'(1);
  localparam logic [BW-1:0] c_bit_last  = BW'(W - 1);
  localparam logic [BW-1:0] c_bit_one   = BW'(1);

  logic [1:0]    r_state;
  logic [FW-1:0] r_fill;
  logic [SW-2:0] r_sync_sr;
  logic [W-1:0]  r_data_sr;
  logic [BW-1:0] r_bit_cnt;
  logic [W-1:0]  r_word;
  logic          r_valid;
  logic          r_perr;
  logic          r_ovf;

  logic [SW-1:0] w_sync_window;
  logic          w_match;
  logic          w_parity_ok;
  logic          w_take;

  // Only SW-1 history bits are stored; the incoming bit completes the window.
  assign w_sync_window = {r_sync_sr, d_in};
  assign w_match       = (w_sync_window == SYNC) && (r_fill >= c_fill_arm);
  assign w_parity_ok   = ~^{r_data_sr, d_in};
  assign w_take        = r_valid & ready_in;

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      r_state   <= S_HUNT;
      r_fill    <= '0;
      r_sync_sr <= '0;
      r_data_sr <= '0;
      r_bit_cnt <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      if (w_take)
        r_valid <= 1'b0;
      if (clr_ovf_in)
        r_ovf <= 1'b0;

      if (bit_en_in) begin
        case (r_state)
          S_HUNT: begin
            r_sync_sr <= w_sync_window[SW-2:0];
            if (r_fill != c_fill_full)
              r_fill <= r_fill + c_fill_one;
            if (w_match) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_data_sr <= {r_data_sr[W-2:0], d_in};
            r_bit_cnt <= r_bit_cnt + c_bit_one;
            if (r_bit_cnt == c_bit_last)
              r_state <= S_PARITY;
          end
          S_PARITY: begin
            // A new load overrides the same-cycle transfer, keeping valid high.
            if (w_parity_ok) begin
              if (!r_valid || ready_in) begin
                r_word  <= r_data_sr;
                r_valid <= 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
            end else begin
              r_perr <= 1'b1;
            end
            r_state   <= S_HUNT;
            r_sync_sr <= '0;
            r_fill    <= '0;
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign word_out       = r_word;
  assign valid_out      = r_valid;
  assign parity_err_out = r_perr;
  assign overflow_out   = r_ovf;
  assign busy_out       = (r_state != S_HUNT);

endmodule
`default_nettype wire
